counter_sweep_ctrl: RTL and testbench
=====================================

// Module: counter_sweep_ctrl
// PURPOSE
//   Sequencer for the team's up/down counter (with load/enable). On a start
//   request it loads the counter with a low bound, then steps it up to a high
//   bound (single sweep) or up and back down (ping-pong). It repeats this a
//   programmed number of passes, then pulses done. It owns the counter's
//   load/en/up controls; the counter's q is fed back as cnt_q.
// PARAMETERS
//   WIDTH     4  counter/bound width in bits
//   REPEAT_W  4  width of pass-count field
// PORTS
//   clk           in   1         clock, all state updates on rising edge
//   rst           in   1         asynchronous, active-high reset
//   start         in   1         start request, sampled only in IDLE
//   abort         in   1         stop sequence, return to IDLE
//   mode          in   1         0 = single up-sweep, 1 = ping-pong (up then down)
//   lo            in   WIDTH     low bound, latched on accepted start
//   hi            in   WIDTH     high bound, latched on accepted start
//   repeat_n      in   REPEAT_W  number of passes; 0 treated as 1
//   cnt_q         in   WIDTH     current counter value (registered, from counter)
//   cnt_load      out  1         counter load strobe
//   cnt_load_val  out  WIDTH     value to load (= latched lo)
//   cnt_en        out  1         counter count enable
//   cnt_up        out  1         counter direction, 1 = up
//   busy          out  1         high in every state except IDLE
//   done          out  1         1-cycle pulse, sequence completed
//   cfg_err       out  1         1-cycle pulse, start rejected (lo > hi)
//   aborted       out  1         1-cycle pulse, sequence aborted
// BEHAVIOUR
//   Reset: state = IDLE; lo_r, hi_r, mode_r, rep_r, pass_cnt = 0.
//     All outputs are 0, including cnt_load_val.
//   States: IDLE, LOAD, UP, DOWN, DONE. Encoding is free.
//   Outputs are decoded from state plus cnt_q; the pulses done, cfg_err and
//     aborted are registered.
//   IDLE: if start && !abort, latch lo, hi, mode, repeat_n and clear pass_cnt.
//     If lo > hi: pulse cfg_err next cycle and stay IDLE. Otherwise go to LOAD.
//   LOAD: cnt_load = 1 and cnt_load_val = lo_r for exactly one cycle; then UP.
//   UP: cnt_up = 1 and cnt_en = (cnt_q != hi_r).
//     When cnt_q == hi_r and mode_r = 1, go to DOWN.
//     When cnt_q == hi_r and mode_r = 0, do pass_cnt++; go to DONE if the
//     incremented count equals eff_rep, else go to LOAD.
//   DOWN: cnt_up = 0 and cnt_en = (cnt_q != lo_r).
//     When cnt_q == lo_r, do pass_cnt++; go to DONE if the count equals
//     eff_rep, else go to UP with no reload.
//   eff_rep = (rep_r == 0) ? 1 : rep_r.
//   DONE: done = 1 for one cycle, then IDLE.
//   abort (any non-IDLE state, including LOAD): cnt_en and cnt_load are forced
//     to 0 that cycle. Next state is IDLE, aborted pulses, done stays low.
//     abort has priority over start and over any pass completion in the same
//     cycle.
//   start while busy is ignored; it is not queued.
//   lo == hi is legal: each pass takes one UP cycle (plus one DOWN cycle in
//     ping-pong), with cnt_en held 0.
//   Latency, measured from the edge E0 that accepts start to the edge after
//     which done is high:
//     mode 0: rep * (hi - lo + 2) edges.
//     mode 1: 1 + rep * (2*(hi - lo) + 2) edges.
//   Bounds never wrap: the controller never enables counting past hi or
//     below lo.
//   Async rst mid-sequence returns to the reset state immediately; no done
//     or aborted pulse.
// TESTING
//   1. rst held, then released: all outputs 0, busy 0; start ignored while
//      rst is high.
//   2. mode=0, lo=2, hi=5, rep=1: one LOAD cycle, cnt_en high for 3 cycles,
//      q ends at 5, done 5 edges after start.
//   3. mode=1, lo=0, hi=3, rep=2: q sequence 0..3..0..3..0, done at edge 17,
//      exactly one done pulse.
//   4. lo=7, hi=3, start: cfg_err one cycle, busy stays 0, no cnt_load.
//   5. mode=1, lo=0, hi=15, rep=0: q reaches 15 then returns to 0, done once
//      (rep 0 acts as 1), no wrap past 15.
//   6. abort in mid-DOWN with start held high: aborted pulse, cnt_en 0 that
//      cycle, IDLE next, no done. Also assert rst during UP: outputs 0
//      asynchronously.

Source files
------------

// File: rtl/counter_sweep_if.sv
// Control/status bundle between the sweep sequencer and whoever drives it.
// The slave side is the sequencer; cnt_q comes back from the external counter.
interface counter_sweep_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned REPEAT_W = 4
);
  logic                start;
  logic                abort;
  logic                mode;
  logic [WIDTH-1:0]    lo;
  logic [WIDTH-1:0]    hi;
  logic [REPEAT_W-1:0] repeat_n;
  logic [WIDTH-1:0]    cnt_q;
  logic                cnt_load;
  logic [WIDTH-1:0]    cnt_load_val;
  logic                cnt_en;
  logic                cnt_up;
  logic                busy;
  logic                done;
  logic                cfg_err;
  logic                aborted;

  modport slave (
    input  start, abort, mode, lo, hi, repeat_n, cnt_q,
    output cnt_load, cnt_load_val, cnt_en, cnt_up, busy, done, cfg_err, aborted
  );

  modport master (
    output start, abort, mode, lo, hi, repeat_n, cnt_q,
    input  cnt_load, cnt_load_val, cnt_en, cnt_up, busy, done, cfg_err, aborted
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for the up/down counter: load lo, count to hi (and back to
// lo in ping-pong mode), repeat for the programmed number of passes.
module counter_sweep_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned REPEAT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  counter_sweep_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_lo;
  logic [WIDTH-1:0]    r_hi;
  logic                r_mode;
  logic [REPEAT_W-1:0] r_rep;
  logic [REPEAT_W-1:0] r_pass;
  logic                r_done;
  logic                r_cfg_err;
  logic                r_aborted;

  logic [REPEAT_W-1:0] w_eff_rep;
  logic [REPEAT_W-1:0] w_pass_inc;
  logic                w_last;
  logic                w_at_hi;
  logic                w_at_lo;

  // A programmed pass count of zero runs a single pass.
  assign w_eff_rep  = (r_rep == '0) ? REPEAT_W'(1) : r_rep;
  assign w_pass_inc = r_pass + REPEAT_W'(1);
  assign w_last     = (w_pass_inc == w_eff_rep);
  assign w_at_hi    = (bus.cnt_q == r_hi);
  assign w_at_lo    = (bus.cnt_q == r_lo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lo      <= '0;
      r_hi      <= '0;
      r_mode    <= 1'b0;
      r_rep     <= '0;
      r_pass    <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_aborted <= 1'b0;
      // Abort outranks start and any pass completion in the same cycle.
      if (r_state != S_IDLE && bus.abort) begin
        r_state   <= S_IDLE;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              r_lo   <= bus.lo;
              r_hi   <= bus.hi;
              r_mode <= bus.mode;
              r_rep  <= bus.repeat_n;
              r_pass <= '0;
              if (bus.lo > bus.hi) r_cfg_err <= 1'b1;
              else                 r_state   <= S_LOAD;
            end
          end
          S_LOAD: r_state <= S_UP;
          S_UP: begin
            if (w_at_hi) begin
              if (r_mode) begin
                r_state <= S_DOWN;
              end else begin
                r_pass <= w_pass_inc;
                if (w_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= S_LOAD;
                end
              end
            end
          end
          S_DOWN: begin
            if (w_at_lo) begin
              r_pass <= w_pass_inc;
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_UP;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Counter controls follow the live cnt_q so counting stops exactly at a bound.
  assign bus.cnt_load     = (r_state == S_LOAD) && !bus.abort;
  assign bus.cnt_load_val = r_lo;
  assign bus.cnt_en       = !bus.abort &&
                            (((r_state == S_UP)   && !w_at_hi) ||
                             ((r_state == S_DOWN) && !w_at_lo));
  assign bus.cnt_up       = (r_state == S_UP);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = r_done;
  assign bus.cfg_err      = r_cfg_err;
  assign bus.aborted      = r_aborted;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: behavioural up/down counter closes the loop,
// table of sweep configurations plus directed reset/abort/config-error cases.
module tb_counter_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  counter_sweep_if #(.WIDTH(4), .REPEAT_W(4)) bus ();

  counter_sweep_ctrl #(.WIDTH(4), .REPEAT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External counter being sequenced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               bus.cnt_q <= 4'd0;
    else if (bus.cnt_load) bus.cnt_q <= bus.cnt_load_val;
    else if (bus.cnt_en)   bus.cnt_q <= bus.cnt_up ? bus.cnt_q + 4'd1 : bus.cnt_q - 4'd1;
  end

  typedef struct {
    logic       mode;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] rep;
    int         exp_lat;
    int         exp_en;
    int         exp_ld;
    int         exp_q;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_all();
    return {bus.cnt_load, bus.cnt_load_val, bus.cnt_en, bus.cnt_up,
            bus.busy, bus.done, bus.cfg_err, bus.aborted};
  endfunction

  task automatic launch(input logic m, input logic [3:0] l, input logic [3:0] h,
                        input logic [3:0] r, input logic hold_start);
    @(negedge clk);
    bus.mode = m; bus.lo = l; bus.hi = h; bus.repeat_n = r; bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;
  endtask

  // Runs one sweep from the accepting edge; cycle 0 is the cycle right after it.
  task automatic run_vec(input vec_t v, input int idx);
    int lat, en_c, ld_c, done_c, q_fin, qmin, qmax, lv_bad;
    lat = -1; en_c = 0; ld_c = 0; done_c = 0; q_fin = -1;
    qmin = 99; qmax = -1; lv_bad = 0;
    launch(v.mode, v.lo, v.hi, v.rep, 1'b0);
    for (int k = 0; k < 400; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (bus.cnt_en) en_c++;
      if (bus.cnt_load) begin
        ld_c++;
        if (bus.cnt_load_val != v.lo) lv_bad++;
      end else if (bus.busy && !bus.done) begin
        if (int'(bus.cnt_q) < qmin) qmin = int'(bus.cnt_q);
        if (int'(bus.cnt_q) > qmax) qmax = int'(bus.cnt_q);
      end
      if (bus.done) begin
        done_c++;
        if (lat < 0) begin
          lat   = k;
          q_fin = int'(bus.cnt_q);
        end
      end
      if (lat >= 0 && k >= lat + 3) break;
    end
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d en_cycles", idx), en_c, v.exp_en);
    check($sformatf("v%0d loads", idx), ld_c, v.exp_ld);
    check($sformatf("v%0d load_val_bad", idx), lv_bad, 0);
    check($sformatf("v%0d done_pulses", idx), done_c, 1);
    check($sformatf("v%0d q_at_done", idx), q_fin, v.exp_q);
    check($sformatf("v%0d q_min", idx), qmin, int'(v.lo));
    check($sformatf("v%0d q_max", idx), qmax, int'(v.hi));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found, dn;
    vecs[0] = '{1'b0, 4'd2, 4'd5,  4'd1, 5,  3,  1, 5};
    vecs[1] = '{1'b1, 4'd0, 4'd3,  4'd2, 17, 12, 1, 0};
    vecs[2] = '{1'b1, 4'd0, 4'd15, 4'd0, 33, 30, 1, 0};
    vecs[3] = '{1'b0, 4'd6, 4'd6,  4'd3, 6,  0,  3, 6};
    vecs[4] = '{1'b1, 4'd9, 4'd9,  4'd2, 5,  0,  1, 9};
    vecs[5] = '{1'b0, 4'd1, 4'd3,  4'd2, 8,  4,  2, 3};

    // Reset held with a live start request: nothing may start.
    bus.start = 1'b1; bus.abort = 1'b0; bus.mode = 1'b0;
    bus.lo = 4'd1; bus.hi = 4'd4; bus.repeat_n = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_held_outputs", outs_all(), 0);
    check("rst_held_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    check("rst_release_outputs", outs_all(), 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // lo > hi is rejected with a one-cycle cfg_err.
    launch(1'b0, 4'd7, 4'd3, 4'd1, 1'b0);
    check("cfgerr_pulse", int'(bus.cfg_err), 1);
    check("cfgerr_busy", int'(bus.busy), 0);
    check("cfgerr_load", int'(bus.cnt_load), 0);
    @(posedge clk); #1;
    check("cfgerr_clear", int'(bus.cfg_err), 0);
    check("cfgerr_busy2", int'(bus.busy), 0);
    check("cfgerr_load2", int'(bus.cnt_load), 0);

    // Abort during LOAD.
    launch(1'b0, 4'd0, 4'd5, 4'd1, 1'b0);
    check("abload_load_before", int'(bus.cnt_load), 1);
    bus.abort = 1'b1; #1;
    check("abload_load_forced", int'(bus.cnt_load), 0);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abload_aborted", int'(bus.aborted), 1);
    check("abload_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    check("abload_aborted_clear", int'(bus.aborted), 0);

    // Abort mid-DOWN with start still held.
    launch(1'b1, 4'd0, 4'd3, 4'd1, 1'b1);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (bus.busy && !bus.cnt_up && bus.cnt_en) begin
        found = 1;
        break;
      end
    end
    check("abdown_reached_down", found, 1);
    bus.abort = 1'b1; #1;
    check("abdown_en_forced", int'(bus.cnt_en), 0);
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.start = 1'b0;
    check("abdown_aborted", int'(bus.aborted), 1);
    check("abdown_busy", int'(bus.busy), 0);
    check("abdown_done", int'(bus.done), 0);
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dn++;
    end
    check("abdown_stays_idle", dn, 0);

    // Asynchronous reset during UP.
    launch(1'b0, 4'd0, 4'd10, 4'd1, 1'b0);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (bus.busy && bus.cnt_up && bus.cnt_en) begin
        found = 1;
        break;
      end
    end
    check("rstup_reached_up", found, 1);
    #2 rst = 1'b1; #1;
    check("rstup_async_outputs", outs_all(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstup_after_outputs", outs_all(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
